// File: rtl/return_stack.sv
// return_stack: hardware LIFO for stk-push/pop instructions.
// tos is a register that mirrors entry count-1. Because of this, a pop can steer
// the top value to the PC or register-write mux combinationally in its e1 cycle.
// Optional macro STACK_ERR_FLAGS_EN builds sticky overflow/underflow flags.
// Without the macro, both flags are tied to 0.
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pushEn,
  input  logic             popEn,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] tos,
  output logic             stackFull,
  output logic             stackEmpty,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] TWO      = (PTR_W+1)'(2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   cnt;
  logic [WIDTH-1:0] tos_q;

  logic             empty, full;
  logic             do_push, do_pop, do_repl;
  logic [PTR_W-1:0] top_idx, below_idx, wr_idx;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

  // Push+pop on an empty stack degrades to a plain push.
  // Push+pop on a non-empty stack (full included) replaces the top entry.
  assign do_repl = pushEn & popEn & ~empty;
  assign do_push = pushEn & ((~popEn & ~full) | (popEn & empty));
  assign do_pop  = popEn & ~pushEn & ~empty;

  assign top_idx   = PTR_W'(cnt - ONE);
  assign below_idx = PTR_W'(cnt - TWO);
  assign wr_idx    = do_repl ? top_idx : cnt[PTR_W-1:0];

  assign tos        = tos_q;
  assign count      = cnt;
  assign stackFull  = full;
  assign stackEmpty = empty;

  // Storage write. The array is not cleared on reset.
  // A reset in the same cycle as a write suppresses that write.
  always_ff @(posedge clk) begin
    if (!reset && (do_push || do_repl))
      mem[wr_idx] <= push_data;
  end

  // Count and top-of-stack register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      tos_q <= '0;
    end else if (do_push) begin
      cnt   <= cnt + ONE;
      tos_q <= push_data;
    end else if (do_repl) begin
      tos_q <= push_data;
    end else if (do_pop) begin
      cnt   <= cnt - ONE;
      tos_q <= (cnt >= TWO) ? mem[below_idx] : '0;
    end
  end

`ifdef STACK_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  // Sticky misuse flags. Each asserts the cycle after the offending strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (pushEn && !popEn && full)  ovf_q <= 1'b1;
      if (popEn && !pushEn && empty) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware LIFO stack that consumes the decoder's pushEn/popEn strobes and supplies the stackFull/stackEmpty flags the decoder gates on.
- Holds values pushed by stk-push instructions.
- Presents the current top-of-stack so that, in the same e1 cycle as a pop, the value can be steered to the PC mux (pcmux_sel=10) or the register-write mux (mux1_sel=11).
- Sits beside the register file and PC in the datapath, clocked with the core.

Parameters:
- WIDTH, 16, data word width (matches instruction/PC/register width).
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; count is PTR_W+1 bits.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pushEn  input  1  push strobe, one cycle per push (decoder psh&e1).
- popEn  input  1  pop strobe, one cycle per pop (decoder pop&e1).
- push_data  input  WIDTH  value written on push.
- tos  output  WIDTH  registered top-of-stack; valid whenever stackEmpty=0.
- stackFull  output  1  count==DEPTH.
- stackEmpty  output  1  count==0.
- count  output  PTR_W+1  number of valid entries.
- overflow  output  1  sticky push-while-full flag (see Optional Feature).
- underflow  output  1  sticky pop-while-empty flag (see Optional Feature).

Behaviour:
- Reset (synchronous, has priority over everything): count=0, tos=0, stackEmpty=1, stackFull=0, overflow=0, underflow=0. Memory array is not cleared. A reset in the same cycle as a push or pop discards that operation.
- Storage: DEPTH x WIDTH array. Entry i holds the i-th oldest value. tos is a register mirroring entry count-1, so it has no combinational path from pushEn/popEn/push_data.
- Push only (pushEn=1, popEn=0, not full): mem[count]<=push_data; tos<=push_data; count<=count+1. Takes effect at the next edge; tos reflects the new value one cycle after the strobe.
- Pop only (popEn=1, pushEn=0, not empty): count<=count-1.
  - tos<=mem[count-2] if count>=2, else tos<=0.
  - The popped value is the tos present during the popEn cycle; the consumer samples it combinationally in that same cycle.
- Push and pop together, not empty: replace top. mem[count-1]<=push_data; tos<=push_data; count unchanged.
- Push and pop together, empty: treated as a plain push (the pop is ignored).
- Push while full (without a simultaneous pop): ignored. Memory, tos and count are unchanged.
- Pop while empty: ignored. tos stays 0.
- The decoder already gates on the flags; these rules hold regardless.
- Flags and count: stackFull, stackEmpty and count are derived from the count register. They update on the same edge as the operation, with no extra latency.
- Back-to-back: pushes and pops on consecutive cycles are legal at full rate. No idle cycle is required.

Optional Feature:
- Macro STACK_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any cycle where pushEn=1, popEn=0 and stackFull=1.
  - underflow sets on any cycle where popEn=1, pushEn=0 and stackEmpty=1.
  - Both are sticky until reset and are registered, so each asserts the cycle after the offending strobe.
- Not defined: overflow and underflow are tied to 0 and no flag registers are built. All other behaviour is identical.

Test Plan:
- Reset, then idle: count=0, stackEmpty=1, stackFull=0, tos=0000. Assert reset mid-push sequence: all of these return to reset values on the next edge.
- Push 0x1111, 0x2222, 0x3333 on consecutive cycles, then pop three times: tos reads 3333, 2222, 1111 in the pop cycles. Afterwards count=0, stackEmpty=1, tos=0000.
- Push DEPTH values 0x0100+i: stackFull=1 after the 16th edge, count=16. Push 0xDEAD: count stays 16 and tos stays 0x010F. With STACK_ERR_FLAGS_EN, overflow=1 next cycle and stays 1.
- Pop on empty: count=0, tos=0000, unchanged. With the macro, underflow=1; without it, underflow=0.
- Push 0xAAAA, 0xBBBB, then pushEn=popEn=1 with 0xCCCC: count=2 and tos=CCCC. Pop gives CCCC, then AAAA.
- Alternate push/pop every cycle for 100 cycles with random data against a reference model: tos, count and flags match every cycle.
